pipealu_sched: RTL
==================

Name: pipealu_sched

Overview:
- Issue scheduler in front of the 2-stage pipelined ALU and its 16-entry register file.
- Shares the ALU between NREQ requesters using round-robin arbitration.
- Enforces read-after-write interlock: no register is read before its pending writeback lands, because the ALU has no forwarding.
- Inserts harmless bubbles when nothing can issue, and returns each ALU result tagged with the requester that issued it.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 3, requester-id width; must satisfy 2^IDW >= NREQ.
- RSV_REG, 15, scratch register reserved for bubbles; requesters never write it.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- req_valid  in  NREQ  per-requester instruction valid.
- req_instr  in  16*NREQ  per-requester instruction {op[15:12], rs[11:8], rt[7:4], rd[3:0]}; slice i belongs to requester i.
- req_ready  out  NREQ  one-hot grant, combinational; transfer occurs when valid&ready.
- alu_instr  out  16  registered instruction driven to the ALU instr input.
- alu_out  in  32  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_carry  in  1  ALU carry-out.
- alu_ovf  in  1  ALU overflow.
- rsp_valid  out  1  result valid, one cycle.
- rsp_id  out  IDW  requester that issued the result.
- rsp_data  out  32  copy of alu_out.
- rsp_flags  out  3  {zero, carry, ovf}.
- stall_cnt  out  16  saturating count of hazard-stall cycles.
- guard_err  out  1  illegal-destination drop pulse (feature only; tied 0 otherwise).

Behaviour:
- Bubble encoding: BUBBLE = {4'h0, RSV_REG, RSV_REG, RSV_REG} (AND rsv,rsv->rsv). It writes back an unchanged value, so it is always safe.
- Issue timing: a grant in cycle c loads alu_instr at the end of c. The ALU captures it at the end of c+1, AluOut is valid in c+3, and the regfile is written at the end of c+3.
- Scoreboard: 2-entry shift of {valid, rd} for the last two issued real instructions.
- Hazard rule: candidate i is eligible iff req_valid[i] and neither its rs nor its rt equals a valid scoreboard rd. This gives a minimum spacing of 3 grants between producer and consumer, i.e. 2 intervening bubbles or unrelated issues.
- Arbitration:
  - Round-robin pointer rr. The first eligible requester scanning rr, rr+1, ... (mod NREQ) wins.
  - After a grant to k, rr <= k+1 (mod NREQ). rr is unchanged when nothing is granted.
  - Ineligible requesters are skipped; there is no head-of-line blocking.
- At most one grant per cycle.
- No grant in a cycle: alu_instr <= BUBBLE, and a bubble (valid=0) shifts into the scoreboard.
- Requester duties: hold req_instr stable while valid and not ready. Dropping valid without a transfer is legal.
- Tag pipeline: 3-deep shift of {valid, id}. rsp_valid/rsp_id come from stage 3. rsp_data/rsp_flags pass alu_out and the flags through combinationally while rsp_valid=1; they are 0 otherwise.
- Latency: grant in c -> rsp_valid in c+3. Back-to-back grants give back-to-back responses.
- stall_cnt increments when any req_valid=1 and no grant occurs. It saturates at 16'hFFFF.
- Reset (rst=0 at a clock edge), also mid-operation:
  - alu_instr <= BUBBLE; scoreboard, tags, rsp_valid, stall_cnt and guard_err cleared; rr <= 0; req_ready is 0 while rst=0.
  - In-flight results are discarded; the ALU regfile is reinitialised by the same reset.
- Simultaneous grant and tag retirement is normal pipeline operation; there is no conflict.

Optional Feature:
- Macro: PIPEALU_SCHED_GUARD_EN.
- Defined:
  - A valid request with rd==RSV_REG is still acknowledged (ready=1 when it would win).
  - It is not issued: a BUBBLE is issued instead, no tag enters the pipe, and guard_err pulses for 1 cycle in the grant cycle.
- Undefined: the request issues unmodified and guard_err is tied 0. Correctness of bubbles then relies on requesters honouring RSV_REG.

Decomposition:
- Package pipealu_sched_pkg:
  - opcode constants OP_AND=0, OP_OR=1, OP_ADD=2, OP_SUB=6, OP_SLT=7, OP_NOR=12;
  - instruction field slice constants;
  - BUBBLE function of RSV_REG;
  - scoreboard entry typedef {valid, rd}.
- One sub-module: pipealu_rr_arb, a generic NREQ round-robin arbiter (eligible vector in, one-hot grant out, pointer update).

Test Plan:
- Reset then idle: alu_instr=16'h0FFF every cycle, rsp_valid=0, stall_cnt=0.
- Single request ADD r0,r1->r2 (16'h2012) in cycle 0: ready[0]=1 in cycle 0, rsp_valid=1 with id=0 and data=5 in cycle 3.
- Dependent pair: req0=16'h2012, then req0=16'h2234 (rs=r2). The second is granted exactly 3 cycles after the first, stall_cnt=2, and rsp_data=5+5=10.
- All 4 requesters valid with independent instructions: grants in order 0,1,2,3,0, one per cycle; responses arrive in the same id order 3 cycles later.
- Hazard skip: req0 depends on the in-flight rd while req1 is independent. req1 is granted immediately and req0 after the spacing; rr then advances past the granted index.
- rst low during a burst: the next cycle shows alu_instr=BUBBLE and rsp_valid=0, and pending tags are never reported. With PIPEALU_SCHED_GUARD_EN, a request of 16'h201F gives ready=1 and a guard_err pulse, with no response.

Source files
------------

// File: rtl/pipealu_sched_pkg.sv
// ============================================================================
// pipealu_sched_pkg : opcodes, instruction field helpers and scoreboard types
//                     shared by the pipelined-ALU issue scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipealu_sched_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_OR  = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h6;
    localparam logic [3:0] OP_SLT = 4'h7;
    localparam logic [3:0] OP_NOR = 4'hC;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int RS_MSB = 11;
    localparam int RS_LSB = 8;
    localparam int RT_MSB = 7;
    localparam int RT_LSB = 4;
    localparam int RD_MSB = 3;
    localparam int RD_LSB = 0;

    typedef struct packed {
        logic       valid;
        logic [3:0] rd;
    } sb_entry_t;

    function automatic logic [3:0] op_of(input logic [15:0] ins);
        return ins[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [3:0] rs_of(input logic [15:0] ins);
        return ins[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [3:0] rt_of(input logic [15:0] ins);
        return ins[RT_MSB:RT_LSB];
    endfunction

    function automatic logic [3:0] rd_of(input logic [15:0] ins);
        return ins[RD_MSB:RD_LSB];
    endfunction

    // AND rsv,rsv -> rsv rewrites the scratch register with its own value.
    function automatic logic [15:0] bubble_instr(input logic [3:0] rsv);
        return {OP_AND, rsv, rsv, rsv};
    endfunction

    function automatic logic raw_hazard(input logic [15:0] ins, input sb_entry_t e);
        return e.valid && ((rs_of(ins) == e.rd) || (rt_of(ins) == e.rd));
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipealu_rr_arb.sv
// ============================================================================
// pipealu_rr_arb : generic NREQ-way round-robin arbiter; one-hot grant and
//                  pointer advance to the slot after the winner.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipealu_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_elig,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_gnt_id,
    output logic            o_any
);

    logic [IDW-1:0]  r_rr;
    logic [NREQ-1:0] w_hi;
    logic [IDW-1:0]  w_sel;

    // Requesters at or above the pointer take priority; otherwise wrap around.
    always_comb begin
        w_hi  = '0;
        w_sel = '0;
        for (int j = 0; j < NREQ; j++) begin
            w_hi[j] = i_elig[j] && (j >= int'(r_rr));
        end
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (|w_hi) begin
                if (w_hi[j]) w_sel = IDW'(j);
            end else if (i_elig[j]) begin
                w_sel = IDW'(j);
            end
        end
    end

    assign o_any    = |i_elig;
    assign o_gnt_id = w_sel;

    always_comb begin
        o_grant = '0;
        for (int j = 0; j < NREQ; j++) begin
            o_grant[j] = o_any && (w_sel == IDW'(j));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rr <= '0;
        end else if (o_any) begin
            r_rr <= (w_sel == IDW'(NREQ - 1)) ? '0 : w_sel + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipealu_sched.sv
// ============================================================================
// pipealu_sched : round-robin issue scheduler with RAW interlock and tagged
//                 responses for a 2-stage, forwarding-free pipelined ALU.
// Optional macro PIPEALU_SCHED_GUARD_EN: drop writes to RSV_REG, pulse guard_err.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipealu_sched
    import pipealu_sched_pkg::*;
#(
    parameter int         NREQ    = 4,
    parameter int         IDW     = 3,
    parameter logic [3:0] RSV_REG = 4'hF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [16*NREQ-1:0] req_instr,
    output logic [NREQ-1:0]    req_ready,
    output logic [15:0]        alu_instr,
    input  logic [31:0]        alu_out,
    input  logic               alu_zero,
    input  logic               alu_carry,
    input  logic               alu_ovf,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic [31:0]        rsp_data,
    output logic [2:0]         rsp_flags,
    output logic [15:0]        stall_cnt,
    output logic               guard_err
);

    localparam logic [15:0] c_BUBBLE = bubble_instr(RSV_REG);

    sb_entry_t       r_sb [2];
    logic [IDW:0]    r_tag [3];
    logic [15:0]     r_alu_instr;
    logic [15:0]     r_stall_cnt;

    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_gnt_id;
    logic            w_any;
    logic [15:0]     w_sel_instr;
    logic            w_drop;
    logic            w_issue;

    // Gating with rst keeps req_ready low throughout reset.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_elig[i] = rst && req_valid[i]
                        && !raw_hazard(req_instr[i*16 +: 16], r_sb[0])
                        && !raw_hazard(req_instr[i*16 +: 16], r_sb[1]);
        end
    end

    pipealu_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_elig   (w_elig),
        .o_grant  (w_grant),
        .o_gnt_id (w_gnt_id),
        .o_any    (w_any)
    );

    always_comb begin
        w_sel_instr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) w_sel_instr = req_instr[i*16 +: 16];
        end
    end

`ifdef PIPEALU_SCHED_GUARD_EN
    assign w_drop = w_any && (rd_of(w_sel_instr) == RSV_REG);
`else
    assign w_drop = 1'b0;
`endif

    assign w_issue   = w_any && !w_drop;
    assign guard_err = w_drop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_alu_instr <= c_BUBBLE;
            r_sb[0]     <= '0;
            r_sb[1]     <= '0;
            r_tag[0]    <= '0;
            r_tag[1]    <= '0;
            r_tag[2]    <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_alu_instr <= w_issue ? w_sel_instr : c_BUBBLE;
            r_sb[0]     <= {w_issue, rd_of(w_sel_instr)};
            r_sb[1]     <= r_sb[0];
            r_tag[0]    <= {w_issue, w_gnt_id};
            r_tag[1]    <= r_tag[0];
            r_tag[2]    <= r_tag[1];
            if ((|req_valid) && !w_any && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign req_ready = w_grant;
    assign alu_instr = r_alu_instr;
    assign stall_cnt = r_stall_cnt;
    assign rsp_valid = r_tag[2][IDW];
    assign rsp_id    = r_tag[2][IDW-1:0];
    assign rsp_data  = rsp_valid ? alu_out : 32'd0;
    assign rsp_flags = rsp_valid ? {alu_zero, alu_carry, alu_ovf} : 3'd0;

endmodule

`default_nettype wire
